// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the in-order CPU.
//
// Issues loads/stores to a data memory with a ready handshake, stalls the
// upstream stages while an access is outstanding, and aborts an access that
// waits longer than TIMEOUT_CYC cycles. Misaligned accesses and timeouts are
// flagged through mem_err_out. OP_HALT retires once and then parks the stage
// until reset.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   valid_in            EX/MEM register holds a valid instruction
//   rd_in, op_in        destination register, opcode
//   alu_in              ALU result / byte address for loads and stores
//   store_data_in       store data
//   stall_out           upstream must hold all *_in stable while high
//   dmem_req/we/addr/wdata   data memory request side
//   dmem_ready/rdata    data memory completion + read data
//   valid_out, rd_out, op_out, mem_data_out, alu_out, mem_err_out
//                       registered MEM/WB fields
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [3:0]  rd_in,
  input  logic [3:0]  op_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [3:0]  rd_out,
  output logic [3:0]  op_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_out,
  output logic        mem_err_out
);

  // Opcode encoding shared with the rest of the CPU.
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_HALT  = 4'd4;

  // Counter must be able to hold the value TIMEOUT_CYC itself.
  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic is_mem;
  logic misaligned;
  logic timed_out;
  logic req;
  logic stall;
  logic complete;
  logic err;

  assign is_mem     = valid_in && (op_in == OP_LOAD || op_in == OP_STORE);
  assign misaligned = (alu_in[1:0] != 2'b00);
  assign timed_out  = (cnt_q == TO_VAL);

  // Next-state / handshake decode. "complete" marks the cycle whose edge
  // retires the current instruction into the output register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (is_mem) begin
            if (misaligned) begin
              complete = 1'b1;
              err      = 1'b1;
            end else begin
              req = 1'b1;
              if (dmem_ready) begin
                complete = 1'b1;
              end else begin
                stall   = 1'b1;
                state_d = WAIT;
                cnt_d   = '0;
              end
            end
          end else begin
            complete = 1'b1;
            if (op_in == OP_HALT) begin
              state_d = HALTED;
            end
          end
        end
      end
      WAIT: begin
        // Upstream holds the inputs stable, so addr/we/wdata driven from
        // them stay unchanged for the whole wait.
        if (timed_out) begin
          // Request is dropped; any dmem_ready this cycle is ignored.
          complete = 1'b1;
          err      = 1'b1;
          state_d  = IDLE;
        end else begin
          req = 1'b1;
          if (dmem_ready) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem_req   = req;
  assign dmem_we    = req && (op_in == OP_STORE);
  assign dmem_addr  = alu_in;
  assign dmem_wdata = store_data_in;
  assign stall_out  = stall;

  // State, wait counter and MEM/WB output register. Non-completing cycles
  // insert a bubble (valid_out = 0) and leave the other fields untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_out    <= 1'b0;
      rd_out       <= 4'd0;
      op_out       <= 4'd0;
      mem_data_out <= 32'd0;
      alu_out      <= 32'd0;
      mem_err_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_out <= complete;
      if (complete) begin
        rd_out      <= rd_in;
        op_out      <= op_in;
        alu_out     <= alu_in;
        mem_err_out <= err;
        // Read data is only taken on a successful load completion; stores,
        // faults and ALU ops write back zero here.
        mem_data_out <= (!err && op_in == OP_LOAD) ? dmem_rdata : 32'd0;
      end
    end
  end

  // Encodings not referenced by the decode above, kept for readability.
  logic unused_ops;
  assign unused_ops = ^{OP_ADD, OP_ADDI};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage (TIMEOUT_CYC=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later and registered outputs 1 unit after the next edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_HALT  = 4'd4;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [3:0]  rd_in;
  logic [3:0]  op_in;
  logic [31:0] alu_in;
  logic [31:0] store_data_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [3:0]  rd_out;
  logic [3:0]  op_out;
  logic [31:0] mem_data_out;
  logic [31:0] alu_out;
  logic        mem_err_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .rd_in         (rd_in),
    .op_in         (op_in),
    .alu_in        (alu_in),
    .store_data_in (store_data_in),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .valid_out     (valid_out),
    .rd_out        (rd_out),
    .op_out        (op_out),
    .mem_data_out  (mem_data_out),
    .alu_out       (alu_out),
    .mem_err_out   (mem_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd);
    valid_in      = v;
    op_in         = op;
    rd_in         = rd;
    alu_in        = alu;
    store_data_in = sd;
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'd0);
    chk({tag, ".err"},   32'(mem_err_out), 32'd0);
    chk({tag, ".rd"},    32'(rd_out), 32'd0);
    chk({tag, ".op"},    32'(op_out), 32'd0);
    chk({tag, ".mdata"}, mem_data_out, 32'd0);
    chk({tag, ".alu"},   alu_out, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, OP_LOAD, 4'd1, 32'h100, 32'h0);

    // Reset: request and stall suppressed while rst is high.
    #1;
    chk("rst.req",   32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(stall_out), 32'd0);
    tick();
    tick();
    chk_outputs_zero("rst");
    $display("[TB] reset done");

    // ADDI rd=3 alu=0x10: single-cycle pass-through.
    rst = 1'b0;
    drive(1'b1, OP_ADDI, 4'd3, 32'h10, 32'h0);
    #1;
    chk("addi.stall", 32'(stall_out), 32'd0);
    chk("addi.req",   32'(dmem_req), 32'd0);
    tick();
    chk("addi.valid", 32'(valid_out), 32'd1);
    chk("addi.rd",    32'(rd_out), 32'd3);
    chk("addi.op",    32'(op_out), 32'(OP_ADDI));
    chk("addi.alu",   alu_out, 32'h10);
    chk("addi.mdata", mem_data_out, 32'd0);
    chk("addi.err",   32'(mem_err_out), 32'd0);
    drive(1'b0, OP_ADD, 4'd0, 32'h0, 32'h0);
    tick();
    chk("bubble.valid", 32'(valid_out), 32'd0);
    chk("bubble.rd",    32'(rd_out), 32'd3);
    $display("[TB] addi rd=3 alu=0x10 done");

    // LOAD 0x100, ready after 3 stall cycles; rdata garbage until then.
    drive(1'b1, OP_LOAD, 4'd5, 32'h100, 32'h0);
    dmem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld.req",   32'(dmem_req), 32'd1);
      chk("ld.addr",  dmem_addr, 32'h100);
      chk("ld.we",    32'(dmem_we), 32'd0);
      chk("ld.stall", 32'(stall_out), 32'd1);
      tick();
      chk("ld.bubble", 32'(valid_out), 32'd0);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld.req_done",   32'(dmem_req), 32'd1);
    chk("ld.stall_done", 32'(stall_out), 32'd0);
    tick();
    chk("ld.valid", 32'(valid_out), 32'd1);
    chk("ld.mdata", mem_data_out, 32'hDEADBEEF);
    chk("ld.rd",    32'(rd_out), 32'd5);
    chk("ld.err",   32'(mem_err_out), 32'd0);
    $display("[TB] load 0x100 3-wait rdata=deadbeef done");

    // STORE 0x20 data 0x55, zero-wait.
    drive(1'b1, OP_STORE, 4'd6, 32'h20, 32'h55);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("st.req",   32'(dmem_req), 32'd1);
    chk("st.we",    32'(dmem_we), 32'd1);
    chk("st.addr",  dmem_addr, 32'h20);
    chk("st.wdata", dmem_wdata, 32'h55);
    chk("st.stall", 32'(stall_out), 32'd0);
    tick();
    chk("st.valid", 32'(valid_out), 32'd1);
    chk("st.mdata", mem_data_out, 32'd0);
    chk("st.op",    32'(op_out), 32'(OP_STORE));
    $display("[TB] store 0x20 data=0x55 done");

    // Misaligned LOAD 0x102: no request even with ready high.
    drive(1'b1, OP_LOAD, 4'd7, 32'h102, 32'h0);
    #1;
    chk("mis.req",   32'(dmem_req), 32'd0);
    chk("mis.stall", 32'(stall_out), 32'd0);
    tick();
    chk("mis.valid", 32'(valid_out), 32'd1);
    chk("mis.err",   32'(mem_err_out), 32'd1);
    chk("mis.mdata", mem_data_out, 32'd0);
    drive(1'b1, OP_ADD, 4'd2, 32'h33, 32'h0);
    dmem_ready = 1'b0;
    tick();
    chk("add.err_clr", 32'(mem_err_out), 32'd0);
    chk("add.alu",     alu_out, 32'h33);
    $display("[TB] misaligned load 0x102 done");

    // Timeout: LOAD 0x40 with ready low; 1 issue + 4 wait cycles of request.
    drive(1'b1, OP_LOAD, 4'd8, 32'h40, 32'h0);
    dmem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to.req",   32'(dmem_req), 32'd1);
      chk("to.stall", 32'(stall_out), 32'd1);
      tick();
      chk("to.bubble", 32'(valid_out), 32'd0);
    end
    #1;
    chk("to.req_drop", 32'(dmem_req), 32'd0);
    chk("to.stall_end", 32'(stall_out), 32'd0);
    tick();
    chk("to.valid", 32'(valid_out), 32'd1);
    chk("to.err",   32'(mem_err_out), 32'd1);
    chk("to.mdata", mem_data_out, 32'd0);
    chk("to.rd",    32'(rd_out), 32'd8);
    $display("[TB] load 0x40 timeout done");

    // HALT passes once, then the following load is ignored.
    drive(1'b1, OP_HALT, 4'd0, 32'h77, 32'h0);
    #1;
    chk("halt.stall", 32'(stall_out), 32'd0);
    tick();
    chk("halt.valid", 32'(valid_out), 32'd1);
    chk("halt.op",    32'(op_out), 32'(OP_HALT));
    drive(1'b1, OP_LOAD, 4'd9, 32'h80, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("halted.req",   32'(dmem_req), 32'd0);
      chk("halted.stall", 32'(stall_out), 32'd0);
      tick();
      chk("halted.valid", 32'(valid_out), 32'd0);
    end
    $display("[TB] halt then load done");

    // Reset out of HALTED, load output fields, then reset mid-WAIT.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, OP_ADD, 4'd9, 32'hABC, 32'h0);
    tick();
    chk("post.valid", 32'(valid_out), 32'd1);
    chk("post.alu",   alu_out, 32'hABC);
    drive(1'b1, OP_LOAD, 4'd10, 32'h200, 32'h0);
    #1;
    chk("rw.req0", 32'(dmem_req), 32'd1);
    tick();
    chk("rw.req1",   32'(dmem_req), 32'd1);
    chk("rw.stall1", 32'(stall_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw.rst_req",   32'(dmem_req), 32'd0);
    chk("rw.rst_stall", 32'(stall_out), 32'd0);
    tick();
    chk_outputs_zero("rw");
    rst = 1'b0;
    drive(1'b0, OP_ADD, 4'd0, 32'h0, 32'h0);
    dmem_ready = 1'b1;
    #1;
    chk("idle.req",   32'(dmem_req), 32'd0);
    chk("idle.stall", 32'(stall_out), 32'd0);
    drive(1'b1, OP_ADD, 4'd4, 32'h5, 32'h0);
    dmem_ready = 1'b0;
    tick();
    chk("idle.valid", 32'(valid_out), 32'd1);
    chk("idle.rd",    32'(rd_out), 32'd4);
    $display("[TB] reset mid-wait done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
